// File: rtl/feed_tx.sv
// feed_tx: serializes one (price, quantity) update into a SYNC-framed byte stream with optional XOR checksum
module feed_tx #(
  parameter logic [7:0] SYNC_BYTE   = 8'hAA,
  parameter int         GAP_CYCLES  = 2,
  parameter bit         CHECKSUM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_valid,
  output logic        send_ready,
  input  logic [31:0] price_in,
  input  logic [31:0] quantity_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        packet_sent,
  output logic [15:0] packet_count
);
  typedef enum logic [2:0] {IDLE, SYNC, PAYLOAD, CSUM, GAP} state_t;
  localparam state_t END_STATE = (GAP_CYCLES > 0) ? GAP : IDLE;
  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES - 1);
  state_t state, state_n;
  logic [2:0] idx, idx_n;
  logic [3:0] gap, gap_n;
  logic [31:0] price, qty, price_n, qty_n;
  logic [7:0] csum, csum_n, byte_n;
  logic [63:0] payload_n;
  logic xfer, done;
  always_comb begin
    state_n = state;
    idx_n = idx;
    gap_n = gap;
    price_n = price;
    qty_n = qty;
    csum_n = csum;
    done = 1'b0;
    xfer = tx_valid && tx_ready;
    case (state)
      IDLE: if (send_valid && send_ready) begin
        state_n = SYNC;
        price_n = price_in;
        qty_n = quantity_in;
        csum_n = '0;
      end
      SYNC: if (xfer) begin
        state_n = PAYLOAD;
        idx_n = '0;
      end
      PAYLOAD: if (xfer) begin
        csum_n = csum ^ tx_data;
        idx_n = idx + 3'd1;
        if (idx == 3'd7) begin
          state_n = CHECKSUM_EN ? CSUM : END_STATE;
          done = !CHECKSUM_EN;
          gap_n = GAP_INIT;
        end
      end
      CSUM: if (xfer) begin
        state_n = END_STATE;
        done = 1'b1;
        gap_n = GAP_INIT;
      end
      GAP: begin
        state_n = (gap == 4'd0) ? IDLE : GAP;
        gap_n = gap - 4'd1;
      end
      default: state_n = IDLE;
    endcase
    payload_n = {price_n, qty_n};
    byte_n = (state_n == SYNC) ? SYNC_BYTE :
             (state_n == CSUM) ? csum_n : payload_n[{3'd7 - idx_n, 3'b000} +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      gap <= '0;
      price <= '0;
      qty <= '0;
      csum <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      send_ready <= 1'b0;
      packet_sent <= 1'b0;
      packet_count <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      gap <= gap_n;
      price <= price_n;
      qty <= qty_n;
      csum <= csum_n;
      tx_valid <= state_n inside {SYNC, PAYLOAD, CSUM};
      tx_data <= (state_n inside {SYNC, PAYLOAD, CSUM}) ? byte_n : tx_data;
      send_ready <= state_n == IDLE;
      packet_sent <= done;
      packet_count <= packet_count + 16'(done);
    end
  end
endmodule

// File: tb/tb_feed_tx.sv
// tb_feed_tx: directed checks of feed_tx with and without checksum/gap
module tb_feed_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic a_rst, a_send_valid, a_send_ready, a_tx_valid, a_tx_ready, a_packet_sent;
  logic b_rst, b_send_valid, b_send_ready, b_tx_valid, b_tx_ready, b_packet_sent;
  logic [31:0] a_price, a_qty, b_price, b_qty;
  logic [7:0] a_tx_data, b_tx_data;
  logic [15:0] a_packet_count, b_packet_count;
  feed_tx #(.GAP_CYCLES(2), .CHECKSUM_EN(1'b1)) dut_a (
    .clk(clk), .rst(a_rst), .send_valid(a_send_valid), .send_ready(a_send_ready),
    .price_in(a_price), .quantity_in(a_qty), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
    .tx_ready(a_tx_ready), .packet_sent(a_packet_sent), .packet_count(a_packet_count)
  );
  feed_tx #(.GAP_CYCLES(0), .CHECKSUM_EN(1'b0)) dut_b (
    .clk(clk), .rst(b_rst), .send_valid(b_send_valid), .send_ready(b_send_ready),
    .price_in(b_price), .quantity_in(b_qty), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_ready(b_tx_ready), .packet_sent(b_packet_sent), .packet_count(b_packet_count)
  );
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] a_q[$], b_q[$];
  int a_qc[$], b_qc[$], a_acc[$], b_acc[$], a_psc[$], b_psc[$];
  logic [7:0] e1[10] = '{8'hAA, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h64, 8'h42};
  logic [7:0] e2[9] = '{8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01};
  always @(posedge clk) begin
    if (a_tx_valid && a_tx_ready) begin a_q.push_back(a_tx_data); a_qc.push_back(cyc); end
    if (b_tx_valid && b_tx_ready) begin b_q.push_back(b_tx_data); b_qc.push_back(cyc); end
    if (a_send_valid && a_send_ready) a_acc.push_back(cyc);
    if (b_send_valid && b_send_ready) b_acc.push_back(cyc);
    if (a_packet_sent) a_psc.push_back(cyc);
    if (b_packet_sent) b_psc.push_back(cyc);
    cyc <= cyc + 1;
  end
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task a_clear;
    a_q.delete(); a_qc.delete(); a_acc.delete(); a_psc.delete();
  endtask
  task b_clear;
    b_q.delete(); b_qc.delete(); b_acc.delete(); b_psc.delete();
  endtask
  task a_send(input logic [31:0] p, input logic [31:0] q);
    a_price = p;
    a_qty = q;
    a_send_valid = 1'b1;
    for (int i = 0; i < 50 && a_acc.size() == 0; i++) @(negedge clk);
    check("a_accept", a_acc.size(), 1);
    a_send_valid = 1'b0;
  endtask
  task a_wait_bytes(input int n);
    for (int i = 0; i < 200 && a_q.size() < n; i++) @(negedge clk);
    check("a_byte_count", a_q.size(), n);
  endtask
  task a_check_frame(input string tag, input int base);
    for (int i = 0; i < 10; i++) check($sformatf("%s_byte%0d", tag, i), a_q[base + i], e1[i]);
  endtask
  initial begin
    int ps_before;
    a_rst = 1'b1; b_rst = 1'b1;
    a_send_valid = 1'b0; b_send_valid = 1'b0;
    a_tx_ready = 1'b1; b_tx_ready = 1'b1;
    a_price = '0; a_qty = '0; b_price = '0; b_qty = '0;
    @(negedge clk); @(negedge clk);
    check("rst_send_ready", a_send_ready, 0);
    check("rst_tx_valid", a_tx_valid, 0);
    check("rst_tx_data", a_tx_data, 0);
    check("rst_packet_count", a_packet_count, 0);
    check("rst_packet_sent", a_packet_sent, 0);
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("idle_send_ready", a_send_ready, 1);
    // basic frame, send_valid held so the second accept shows the frame period
    a_clear();
    a_price = 32'h00001234; a_qty = 32'h00000064; a_send_valid = 1'b1;
    for (int i = 0; i < 100 && a_acc.size() < 2; i++) @(negedge clk);
    a_send_valid = 1'b0;
    check("basic_accepts", a_acc.size(), 2);
    a_wait_bytes(20);
    repeat (4) @(negedge clk);
    a_check_frame("basic1", 0);
    a_check_frame("basic2", 10);
    check("basic_latency", a_qc[0] - a_acc[0], 1);
    check("basic_contiguous", a_qc[9] - a_qc[0], 9);
    check("basic_pulse_time", a_psc[0] - a_qc[9], 1);
    check("basic_next_accept", a_acc[1] - a_qc[9], 3);
    check("basic_pulses", a_psc.size(), 2);
    check("basic_count", a_packet_count, 2);
    // backpressure on payload byte 2
    a_clear();
    a_send(32'h00001234, 32'h00000064);
    a_wait_bytes(3);
    a_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid%0d", i), a_tx_valid, 1);
      check($sformatf("bp_data%0d", i), a_tx_data, 8'h12);
      @(negedge clk);
    end
    a_tx_ready = 1'b1;
    a_wait_bytes(10);
    repeat (4) @(negedge clk);
    a_check_frame("bp", 0);
    check("bp_count", a_packet_count, 3);
    // busy ignore
    a_clear();
    a_send(32'h00001234, 32'h00000064);
    repeat (3) @(negedge clk);
    a_price = 32'hDEADBEEF; a_qty = 32'h0BADF00D; a_send_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("busy_ready%0d", i), a_send_ready, 0);
      @(negedge clk);
    end
    a_send_valid = 1'b0;
    a_wait_bytes(10);
    repeat (15) @(negedge clk);
    a_check_frame("busy", 0);
    check("busy_accepts", a_acc.size(), 1);
    check("busy_bytes", a_q.size(), 10);
    check("busy_count", a_packet_count, 4);
    // reset while presenting payload byte 4
    a_clear();
    a_send(32'h00001234, 32'h00000064);
    a_wait_bytes(5);
    ps_before = a_psc.size();
    a_rst = 1'b1;
    @(negedge clk);
    check("midrst_tx_valid", a_tx_valid, 0);
    check("midrst_send_ready", a_send_ready, 0);
    check("midrst_count", a_packet_count, 0);
    a_rst = 1'b0;
    repeat (15) @(negedge clk);
    check("midrst_no_pulse", a_psc.size(), ps_before);
    check("midrst_idle_valid", a_tx_valid, 0);
    a_clear();
    a_send(32'h00001234, 32'h00000064);
    a_wait_bytes(10);
    repeat (4) @(negedge clk);
    a_check_frame("postrst", 0);
    check("postrst_count", a_packet_count, 1);
    // no checksum, no gap, back-to-back
    b_clear();
    b_price = 32'hFFFFFFFF; b_qty = 32'h00000001; b_send_valid = 1'b1;
    for (int i = 0; i < 100 && b_acc.size() < 2; i++) @(negedge clk);
    b_send_valid = 1'b0;
    check("nock_accepts", b_acc.size(), 2);
    for (int i = 0; i < 100 && b_q.size() < 18; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("nock_bytes", b_q.size(), 18);
    for (int i = 0; i < 18; i++) check($sformatf("nock_byte%0d", i), b_q[i], e2[i % 9]);
    check("nock_sync_gap", b_qc[9] - b_qc[8], 2);
    check("nock_period", b_acc[1] - b_acc[0], 10);
    check("nock_pulses", b_psc.size(), 2);
    check("nock_count", b_packet_count, 2);
    // counter wrap
    b_clear();
    force dut_b.packet_count = 16'hFFFF;
    @(negedge clk);
    release dut_b.packet_count;
    b_send_valid = 1'b1;
    for (int i = 0; i < 50 && b_acc.size() == 0; i++) @(negedge clk);
    b_send_valid = 1'b0;
    for (int i = 0; i < 100 && b_q.size() < 9; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("wrap_pulse", b_psc.size(), 1);
    check("wrap_count", b_packet_count, 16'h0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/feed_tx.md
Name: feed_tx

Overview:
- Transmit-side counterpart of the market-data feed receiver. Serializes one (price, quantity) order update into the 8-bit framed byte stream the receiver parses.
- Sits between the strategy/test-stimulus logic and the byte-wide "Ethernet" TX path.
- Upstream uses a valid/ready handshake. Downstream is a byte stream with valid/ready backpressure.
- Also counts transmitted packets.

Parameters:
- SYNC_BYTE, 8'hAA: frame start byte.
- GAP_CYCLES, 2: idle cycles forced after each frame; range 0..15.
- CHECKSUM_EN, 1: 1 appends an XOR checksum byte; 0 omits it.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- send_valid  input  1  upstream request to send one update.
- send_ready  output  1  high when the block accepts a new update.
- price_in  input  32  price to send; sampled on accept.
- quantity_in  input  32  quantity to send; sampled on accept.
- tx_data  output  8  serialized byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  downstream accepts the byte this cycle.
- packet_sent  output  1  1-cycle pulse when the final frame byte is accepted.
- packet_count  output  16  total frames completed; wraps.

Behaviour:
- Single clock, synchronous active-high reset. While rst=1 at a rising edge:
  - state=IDLE.
  - send_ready=0, tx_valid=0, tx_data=8'h00.
  - packet_sent=0, packet_count=0.
  - Latched price/quantity and checksum cleared.
- Frame format, byte order on the wire:
  - SYNC_BYTE.
  - price[31:24], price[23:16], price[15:8], price[7:0].
  - qty[31:24], qty[23:16], qty[15:8], qty[7:0].
  - [CSUM], present only when CHECKSUM_EN=1.
  - Frame length is 10 bytes with checksum, 9 without.
- CSUM = XOR of the 8 payload bytes. SYNC_BYTE is excluded.
- States: IDLE, SYNC, PAYLOAD (3-bit byte index 0..7), CSUM, GAP (4-bit counter).
- IDLE:
  - send_ready=1 (registered decode of state; 0 in every other state and during reset).
  - Accept occurs on a cycle with send_valid && send_ready.
  - On accept: latch price_in/quantity_in, clear checksum, go to SYNC.
  - tx_valid rises in the cycle after accept (1-cycle latency).
- Byte transfer:
  - A byte transfers on a cycle with tx_valid && tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data and state hold stable indefinitely.
  - tx_valid never drops mid-frame except on reset.
- Transitions:
  - SYNC → PAYLOAD(0) on transfer.
  - PAYLOAD(i) → PAYLOAD(i+1) on transfer. Each payload byte is XORed into the checksum as it transfers.
  - PAYLOAD(7) → CSUM if CHECKSUM_EN, else frame end.
  - CSUM → frame end on transfer.
- Frame end, on the cycle after the last byte transfers:
  - tx_valid=0.
  - packet_sent=1 for exactly one cycle.
  - packet_count increments; 16'hFFFF → 16'h0000.
  - Go to GAP if GAP_CYCLES>0, else IDLE.
- GAP: tx_valid=0, send_ready=0 for GAP_CYCLES cycles, then IDLE.
- Throughput with tx_ready held at 1: frame period = frame length + GAP_CYCLES + 1 cycles, counted from accept to next accept.
- send_valid while busy is ignored; nothing is queued. Upstream must hold send_valid until send_ready.
- price_in/quantity_in changing after accept do not affect the frame in flight.
- Reset mid-frame: the frame is aborted. Next cycle tx_valid=0, no packet_sent pulse, and packet_count resets to 0.
- tx_data when tx_valid=0: holds its last value; content don't-care.

Test Plan:
- Basic frame: CHECKSUM_EN=1, GAP=2, tx_ready=1; send price=32'h00001234, qty=32'h00000064.
  - Required tx stream: AA 00 00 12 34 00 00 00 64 42 on 10 consecutive cycles, starting 1 cycle after accept.
  - Required after the last byte: packet_sent pulses once, packet_count=1.
  - Required next accept: 3 cycles later.
- Backpressure: same frame with tx_ready low for 5 cycles while PAYLOAD index=2 (byte 12) is presented.
  - Required: tx_data=8'h12 and tx_valid=1 held stable throughout.
  - Required: stream is otherwise identical; checksum still 42.
- Busy ignore: assert send_valid with price=32'hDEADBEEF mid-frame.
  - Required: send_ready=0, the in-flight frame is unaltered, and no second frame is sent.
- Reset mid-frame: assert rst during PAYLOAD index=4.
  - Required next cycle: tx_valid=0, send_ready=0, packet_count=0.
  - Required: no packet_sent pulse.
  - Required after release: the next send produces a complete, correct frame.
- No checksum, no gap: CHECKSUM_EN=0, GAP_CYCLES=0; send price=32'hFFFFFFFF, qty=32'h00000001 twice back-to-back.
  - Required per frame: 9 bytes, AA FF FF FF FF 00 00 00 01.
  - Required: second frame's SYNC appears 2 cycles after the first frame's last byte.
- Counter wrap: preload packet_count to 16'hFFFF (via 65535 frames or a force), then send one frame.
  - Required: packet_count=16'h0000 and a packet_sent pulse.
